// File: rtl/window_sum_4x4_pkg.sv
// Shared filter widths for the 4x4 window sum and the averaging stage behind it.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package window_sum_4x4_pkg;

    localparam int PIXEL_WIDTH_DEF = 8;
    localparam int COLSUM_EXTRA    = 2;
    localparam int SUM_EXTRA       = 4;

    // Widths at the default pixel size.
    localparam int COLSUM_WIDTH = PIXEL_WIDTH_DEF + COLSUM_EXTRA;
    localparam int SUM_WIDTH    = PIXEL_WIDTH_DEF + SUM_EXTRA;

    // Widths for a parameterised pixel size.
    function automatic int colsum_width(input int pixel_width);
        return pixel_width + COLSUM_EXTRA;
    endfunction

    function automatic int sum_width(input int pixel_width);
        return pixel_width + SUM_EXTRA;
    endfunction

endpackage

// File: rtl/window_sum_4x4_line.sv
// One-line pixel delay: circular RAM whose read and write share a wrapping pointer.
// Latency: DEPTH enabled beats from din to dout; the read is combinational.
// Backpressure: none; storage advances only when en=1.
module line_delay #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;

    // The slot about to be overwritten holds the pixel from one line earlier.
    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/window_sum_4x4.sv
// Exact sum of the 4x4 pixel window ending at each accepted pixel of a raster stream.
// Latency: fixed 3 cycles from an accepted beat to its dout_valid pulse, regardless of gaps.
// Backpressure: none; input is accepted on every din_valid beat.
module window_sum_4x4
    import window_sum_4x4_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 640
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   din_valid,
    input  logic                   din_sof,
    input  logic [PIXEL_WIDTH-1:0] din_data,
    output logic                   dout_valid,
    output logic [PIXEL_WIDTH+3:0] dout_data
);

    localparam int CW    = colsum_width(PIXEL_WIDTH);
    localparam int SW    = sum_width(PIXEL_WIDTH);
    localparam int COL_W = $clog2(IMG_WIDTH);

    logic [COL_W-1:0] col, cur_col;
    logic [1:0]       row, cur_row;
    logic             win_ok, last_col;

    // A start-of-frame beat is row 0, col 0 whatever the counters say.
    always_comb begin
        cur_col  = din_sof ? '0 : col;
        cur_row  = din_sof ? '0 : row;
        win_ok   = (cur_row == 2'd3) && (cur_col >= COL_W'(3));
        last_col = (cur_col == COL_W'(IMG_WIDTH - 1));
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            col <= '0;
            row <= '0;
        end else if (din_valid) begin
            if (last_col) begin
                col <= '0;
                row <= (cur_row == 2'd3) ? 2'd3 : cur_row + 2'd1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    logic [PIXEL_WIDTH-1:0] tap1, tap2, tap3;

    line_delay #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH)) u_ld1 (
        .clk(clk), .arstn(arstn), .en(din_valid), .din(din_data), .dout(tap1)
    );
    line_delay #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH)) u_ld2 (
        .clk(clk), .arstn(arstn), .en(din_valid), .din(tap1), .dout(tap2)
    );
    line_delay #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH)) u_ld3 (
        .clk(clk), .arstn(arstn), .en(din_valid), .din(tap2), .dout(tap3)
    );

    logic [3:0][PIXEL_WIDTH-1:0] s1_pix;
    logic                        s1_vld, s1_ok;
    logic [3:0][CW-1:0]          cs;
    logic                        s2_vld, s2_ok;
    logic [CW-1:0]               col_sum;
    logic [SW-1:0]               win_sum;

    always_comb begin
        col_sum = CW'(s1_pix[0]) + CW'(s1_pix[1]) + CW'(s1_pix[2]) + CW'(s1_pix[3]);
        win_sum = SW'(cs[0]) + SW'(cs[1]) + SW'(cs[2]) + SW'(cs[3]);
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            s1_vld     <= 1'b0;
            s1_ok      <= 1'b0;
            s1_pix     <= '0;
            s2_vld     <= 1'b0;
            s2_ok      <= 1'b0;
            cs         <= '0;
            dout_valid <= 1'b0;
            dout_data  <= '0;
        end else begin
            s1_vld <= din_valid;
            if (din_valid) begin
                s1_pix <= {tap3, tap2, tap1, din_data};
                s1_ok  <= win_ok;
            end
            s2_vld <= s1_vld;
            // Column sums shift only on real beats so gaps never age the window.
            if (s1_vld) begin
                cs    <= {cs[2:0], col_sum};
                s2_ok <= s1_ok;
            end
            dout_valid <= s2_vld && s2_ok;
            if (s2_vld && s2_ok) begin
                dout_data <= win_sum;
            end
        end
    end

endmodule

// File: tb/tb_window_sum_4x4.sv
// Directed bench for window_sum_4x4 with IMG_WIDTH=8: constant, ramp, gapped,
// mid-frame sof and mid-frame reset scenarios against a box-sum scoreboard.
module tb_window_sum_4x4;

    localparam int PW = 8;
    localparam int W  = 8;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        din_valid = 1'b0;
    logic        din_sof = 1'b0;
    logic [7:0]  din_data = '0;
    logic        dout_valid;
    logic [11:0] dout_data;

    window_sum_4x4 #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W)) dut (
        .clk(clk), .arstn(arstn), .din_valid(din_valid), .din_sof(din_sof),
        .din_data(din_data), .dout_valid(dout_valid), .dout_data(dout_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int cyc;
        int sum;
    } exp_t;

    exp_t q[$];
    int   got[$];
    int   vld_cnt = 0;
    int   exp_last = 0;
    int   pix [0:15][0:7];
    int   mr = 0;
    int   mc = 0;

    function automatic int got_at(input int idx);
        return (got.size() > idx) ? got[idx] : -1;
    endfunction

    task automatic send(input bit sof, input int val);
        int s;
        @(posedge clk);
        #1;
        din_valid = 1'b1;
        din_sof   = sof;
        din_data  = val[7:0];
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        pix[mr][mc] = val;
        if (mr >= 3 && mc >= 3) begin
            s = 0;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    s += pix[mr-i][mc-j];
            q.push_back('{cyc + 3, s});
        end
        if (mc == W - 1) begin
            mc = 0;
            mr++;
        end else begin
            mc++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            din_valid = 1'b0;
            din_sof   = 1'b0;
        end
    endtask

    // Every cycle: valid must match the scoreboard; data must match or hold.
    always @(negedge clk) begin
        bit exp_v;
        while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
        exp_v = (q.size() > 0) && (q[0].cyc == cyc);
        check_eq("dout_valid", dout_valid, exp_v);
        if (exp_v) begin
            check_eq("dout_data", dout_data, q[0].sum);
            exp_last = q[0].sum;
            void'(q.pop_front());
        end else if (arstn && !dout_valid) begin
            check_eq("hold", dout_data, exp_last);
        end
        if (dout_valid) begin
            got.push_back(int'(dout_data));
            vld_cnt++;
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_vld", dout_valid, 0);
        check_eq("rst_dat", dout_data, 0);
        arstn = 1'b1;
        idle(2);

        // Constant 255 frame.
        got.delete(); vld_cnt = 0;
        for (int k = 0; k < 64; k++) send(k == 0, 255);
        idle(6);
        check_eq("const_cnt", vld_cnt, 25);
        check_eq("const_first", got_at(0), 4080);

        // Ramp col+8*row, continuous.
        got.delete(); vld_cnt = 0;
        for (int k = 0; k < 64; k++) send(k == 0, k);
        idle(6);
        check_eq("ramp_cnt", vld_cnt, 25);
        check_eq("ramp_33", got_at(0), 216);
        check_eq("ramp_34", got_at(1), 232);

        // Same ramp with random gaps.
        got.delete(); vld_cnt = 0;
        for (int k = 0; k < 64; k++) begin
            send(k == 0, k);
            idle($urandom_range(0, 5));
        end
        idle(6);
        check_eq("gap_cnt", vld_cnt, 25);
        check_eq("gap_33", got_at(0), 216);
        check_eq("gap_34", got_at(1), 232);

        // Restart of frame at row 5, col 2.
        got.delete(); vld_cnt = 0;
        for (int k = 0; k < 42; k++) send(k == 0, k);
        for (int k = 0; k < 48; k++) send(k == 0, 100 + k);
        idle(6);
        check_eq("sof_cnt", vld_cnt, 25);
        check_eq("sof_new33", got_at(10), 1816);

        // Reset pulse in the middle of row 4.
        for (int k = 0; k < 36; k++) send(k == 0, k);
        @(posedge clk);
        #1;
        arstn = 1'b0;
        din_valid = 1'b0;
        din_sof = 1'b0;
        q.delete();
        exp_last = 0;
        mr = 0;
        mc = 0;
        #2;
        check_eq("arst_vld", dout_valid, 0);
        check_eq("arst_dat", dout_data, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("arst_vld2", dout_valid, 0);
        check_eq("arst_dat2", dout_data, 0);
        got.delete(); vld_cnt = 0;
        arstn = 1'b1;
        for (int k = 0; k < 48; k++) send(1'b0, 50 + k);
        idle(6);
        check_eq("post_rst_cnt", vld_cnt, 15);
        check_eq("post_rst_33", got_at(0), 1016);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/window_sum_4x4.md
WINDOW_SUM_4X4 -- requirements
Module: window_sum_4x4

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, input pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 640, pixels per line; legal range 4..4096.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port arstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port din_valid  input  1  input pixel beat qualifier.
REQ-006 SHALL have port din_sof  input  1  start of frame; meaningful only when din_valid=1.
REQ-007 SHALL have port din_data  input  PIXEL_WIDTH  unsigned pixel.
REQ-008 SHALL have port dout_valid  output  1  one-cycle pulse per valid window sum.
REQ-009 SHALL have port dout_data  output  PIXEL_WIDTH+4  unsigned sum of the 4x4 window; feeds the averaging stage directly.

Function
REQ-010 SHALL keep a column counter col (0..IMG_WIDTH-1) and a row counter row saturating at 3; both advance only on din_valid=1 beats.
REQ-011 On a beat with din_sof=1, that pixel SHALL be treated as row 0, col 0, regardless of counter state.
REQ-012 On a beat at col=IMG_WIDTH-1, col SHALL wrap to 0 and row SHALL increment (saturating at 3).
REQ-013 SHALL delay each accepted pixel through three chained one-line delays, presenting pixels at (r,c), (r-1,c), (r-2,c), (r-3,c) together.
REQ-014 Stage 1 SHALL register the four column pixels; stage 2 SHALL register their column sum (PIXEL_WIDTH+2 bits); stage 3 SHALL register the sum of the latest four column sums (PIXEL_WIDTH+4 bits).
REQ-015 The column-sum shift register SHALL advance only when a valid beat reaches stage 2.
REQ-016 A beat accepted in cycle T SHALL produce its result in cycle T+3; latency fixed at 3, independent of gaps.
REQ-017 dout_valid SHALL be 1 in cycle T+3 iff the beat at T had row>=3 and col>=3; otherwise 0.
REQ-018 When dout_valid=1, dout_data SHALL equal the exact sum of pixels rows r-3..r, cols c-3..c; no truncation, no overflow possible.
REQ-019 When dout_valid=0, dout_data SHALL hold its last value.
REQ-020 Gaps (din_valid=0) of any length, including across line ends, SHALL not alter window contents or results.
REQ-021 Columns from a previous line SHALL never contribute to a valid output (guaranteed by REQ-017 masking at col<3).
REQ-022 din_sof arriving mid-line or mid-frame SHALL restart counting per REQ-011; stale line-delay contents SHALL be masked by row<3.

Reset
REQ-023 arstn low SHALL clear col, row, all stage valid flags, stage data registers, dout_valid=0 and dout_data=0 immediately.
REQ-024 Line-delay storage content SHALL not require reset; the first three lines after reset are masked by REQ-017.
REQ-025 After reset deassertion without din_sof, the first valid beat SHALL be row 0, col 0.

Structure
REQ-026 The shared filter package/header SHALL hold SUM_WIDTH (PIXEL_WIDTH+4) and COLSUM_WIDTH (PIXEL_WIDTH+2) definitions used by this block and the averaging stage.
REQ-027 A sub-module line_delay (IMG_WIDTH-deep, PIXEL_WIDTH-wide, enable-advanced circular RAM with wrapping pointer) SHALL be instantiated three times.

Verification (IMG_WIDTH=8, PIXEL_WIDTH=8)
REQ-028 Constant frame of 255, continuous valid with sof on first pixel -> first dout_valid 3 cycles after pixel (3,3), dout_data=4080; exactly 5 valid outputs per line from row 3 on.
REQ-029 Pixel value = col+8*row -> at (3,3) dout_data=216, at (3,4) dout_data=232; matches software 4x4 box sum for all outputs.
REQ-030 Same ramp with random 0-5 cycle gaps between beats -> identical dout_data sequence, each dout_valid exactly 3 cycles after its input beat.
REQ-031 din_sof reasserted at row 5, col 2 -> no dout_valid until new (3,3); subsequent sums exclude pre-sof pixels.
REQ-032 arstn pulsed low mid-row 4 -> dout_valid and dout_data read 0 during reset; after release, no valid output before new row 3, col 3.
